// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch, decode, execute, mul/div wait,
// memory access and write-back, and raises a sticky trap on illegal opcodes.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [2:0]  imm_fmt,
    output logic        alu_b_imm,
    output logic        md_start,
    input  logic        md_done,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MDWAIT, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    state_e      state_q, state_d;
    logic [31:0] ir_q;
    logic [31:0] instret_q;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       is_op, is_opimm, is_load, is_store, is_branch;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_md, is_legal;

    assign opcode    = ir_q[6:0];
    assign funct7    = ir_q[31:25];
    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_md     = is_op && (funct7 == 7'b0000001);

    // OP is only legal with the base, alternate (SUB/SRA) or M-extension funct7.
    assign is_legal = is_opimm || is_load || is_store || is_branch || is_lui
                   || is_auipc || is_jal || is_jalr
                   || (is_op && (funct7 == 7'b0000000 || funct7 == 7'b0100000
                                 || funct7 == 7'b0000001));

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        md_start = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        imm_fmt  = 3'd0;

        if (is_opimm || is_load || is_jalr) imm_fmt = 3'd1;
        else if (is_store)                  imm_fmt = 3'd2;
        else if (is_branch)                 imm_fmt = 3'd3;
        else if (is_lui || is_auipc)        imm_fmt = 3'd4;
        else if (is_jal)                    imm_fmt = 3'd5;

        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                md_start = is_md;
                if (is_md)                   state_d = S_MDWAIT;
                else if (is_load || is_store) state_d = S_MEM;
                else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end else                     state_d = S_WB;
            end
            S_MDWAIT: if (md_done) state_d = S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    pc_we   = is_store;
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we   = (ir_q[11:7] != 5'd0);
                pc_we   = 1'b1;
                state_d = S_FETCH;
                if (is_load)                wb_sel = 2'd1;
                else if (is_jal || is_jalr) wb_sel = 2'd2;
                else if (is_md)             wb_sel = 2'd3;
                if (is_jal)                 pc_sel = 2'd1;
                else if (is_jalr)           pc_sel = 2'd2;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_FETCH && imem_ack) ir_q <= imem_rdata;
            if (pc_we) instret_q <= instret_q + 32'd1;
        end
    end

    assign ir        = ir_q;
    assign instret   = instret_q;
    assign illegal   = (state_q == S_TRAP);
    assign alu_b_imm = (imm_fmt != 3'd0) && !is_branch;

endmodule
